// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI read port among NUM_MASTERS refill engines.
// Optional per-master perf counters enabled by defining MEM_READ_ARB_PERF_EN.
module mem_read_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int LEN_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  m_arlen,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_arid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              m_rlast,
  output logic                              s_arvalid,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic [LEN_WIDTH-1:0]              s_arlen,
  output logic [ID_WIDTH-1:0]               s_arid,
  input  logic                              s_arready,
  input  logic                              s_rvalid,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_rlast,
  output logic                              s_rready,
  output logic                              protocol_err
`ifdef MEM_READ_ARB_PERF_EN
  ,
  output logic [NUM_MASTERS*16-1:0]         perf_grants,
  output logic [NUM_MASTERS*16-1:0]         perf_wait
`endif
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PW-1:0]         r_rr_ptr;
  logic [PW-1:0]         r_grant;
  logic [PW-1:0]         w_win;
  logic [PW-1:0]         w_ptr_nxt;
  logic                  w_any;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [ID_WIDTH-1:0]   w_id;
  logic [LEN_WIDTH-1:0]  w_eff_len;
  logic                  w_cnt_hit;
  logic                  w_beat;
  logic                  w_end;
  logic                  w_err_set;

  // first pass covers rr_ptr..N-1, second pass wraps to 0..rr_ptr-1
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_any && m_arvalid[i] && (PW'(i) >= r_rr_ptr)) begin
        w_any = 1'b1;
        w_win = PW'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_any && m_arvalid[i]) begin
        w_any = 1'b1;
        w_win = PW'(i);
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_len  = '0;
    w_id   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win == PW'(i)) begin
        w_addr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_len  = m_arlen[i*LEN_WIDTH +: LEN_WIDTH];
        w_id   = m_arid[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_win == PW'(NUM_MASTERS - 1)) ?
                     '0 : w_win + PW'(1);

  assign w_eff_len = (r_len == '0) ? LEN_WIDTH'(1) : r_len;
  assign w_cnt_hit = ({1'b0, r_beat_cnt} + (LEN_WIDTH+1)'(1))
                     == {1'b0, w_eff_len};
  assign w_beat    = (r_state == DATA) && s_rvalid;
  assign w_end     = w_beat && (s_rlast || w_cnt_hit);
  assign w_err_set = (w_beat && (s_rlast != w_cnt_hit)) ||
                     (s_rvalid && (r_state != DATA));

  always_comb begin
    w_next    = r_state;
    m_arready = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rlast   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          m_arready[w_win] = 1'b1;
          w_next           = ADDR;
        end
      end
      ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) w_next = DATA;
      end
      DATA: begin
        s_rready          = 1'b1;
        m_rvalid[r_grant] = s_rvalid;
        m_rdata           = s_rdata;
        m_rlast           = s_rlast && s_rvalid;
        if (w_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_id       <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_err_set) r_err <= 1'b1;
      if ((r_state == IDLE) && w_any) begin
        r_grant  <= w_win;
        r_rr_ptr <= w_ptr_nxt;
        r_addr   <= w_addr;
        r_len    <= w_len;
        r_id     <= w_id;
      end
      if ((r_state == ADDR) && s_arready) begin
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
      end
    end
  end

  assign s_araddr     = r_addr;
  assign s_arlen      = r_len;
  assign s_arid       = r_id;
  assign protocol_err = r_err;

`ifdef MEM_READ_ARB_PERF_EN
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_perf
    logic [15:0] r_gcnt;
    logic [15:0] r_wcnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_gcnt <= '0;
        r_wcnt <= '0;
      end else begin
        if (m_arready[g] && (r_gcnt != 16'hFFFF))
          r_gcnt <= r_gcnt + 16'd1;
        if (m_arvalid[g] && !m_arready[g] && (r_wcnt != 16'hFFFF))
          r_wcnt <= r_wcnt + 16'd1;
      end
    end
    assign perf_grants[g*16 +: 16] = r_gcnt;
    assign perf_wait[g*16 +: 16]   = r_wcnt;
  end
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scenario bench for mem_read_arbiter: expected beats queued on drive,
// popped and compared when the granted master sees them.
module tb_mem_read_arbiter;
  localparam int N  = 2;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_arvalid;
  logic [N*AW-1:0] m_araddr;
  logic [N*LW-1:0] m_arlen;
  logic [N*IW-1:0] m_arid;
  logic [N-1:0]    m_arready;
  logic [N-1:0]    m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            m_rlast;
  logic            s_arvalid;
  logic [AW-1:0]   s_araddr;
  logic [LW-1:0]   s_arlen;
  logic [IW-1:0]   s_arid;
  logic            s_arready;
  logic            s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic            s_rlast;
  logic            s_rready;
  logic            protocol_err;
`ifdef MEM_READ_ARB_PERF_EN
  logic [N*16-1:0] perf_grants;
  logic [N*16-1:0] perf_wait;
`endif

  int errors = 0;
  int checks = 0;
  logic [N+DW:0] exp_q[$];
  logic [N+DW:0] w_got;
  logic [N+DW:0] w_exp;

  always #5 clk = ~clk;

  mem_read_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arready(m_arready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arid(s_arid),
    .s_arready(s_arready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rready(s_rready), .protocol_err(protocol_err)
`ifdef MEM_READ_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_wait(perf_wait)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_arvalid = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arid    = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a,
                         input logic [LW-1:0] l,
                         input logic [IW-1:0] id);
    m_araddr[m*AW +: AW] = a;
    m_arlen[m*LW +: LW]  = l;
    m_arid[m*IW +: IW]   = id;
  endtask

  task automatic drive_beat(input int m, input logic [DW-1:0] d,
                            input logic last);
    logic [N-1:0] oh;
    oh = '0;
    oh[m] = 1'b1;
    s_rvalid = 1'b1;
    s_rdata  = d;
    s_rlast  = last;
    exp_q.push_back({oh, d, last});
  endtask

  task automatic test_reset();
    m_arvalid = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({m_arready, m_rvalid, m_rdata, m_rlast, s_arvalid, s_araddr,
         s_arlen, s_arid, s_rready, protocol_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got arv=%b sarv=%b addr=%h err=%b",
               m_arready, s_arvalid, s_araddr, protocol_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 26'h0001230, 4'd4, 4'd8);
    m_arvalid = 2'b10;
    #1; checks++;
    if (m_arready !== 2'b10) begin
      errors++;
      $display("FAIL single_grant got=%b exp=10", m_arready);
    end
    tick();
    m_arvalid = '0;
    s_arready = 1'b1;
    #1; checks++;
    if ({s_arvalid, s_araddr, s_arlen, s_arid}
        !== {1'b1, 26'h0001230, 4'd4, 4'd8}) begin
      errors++;
      $display("FAIL single_addr got v=%b a=%h l=%h id=%h",
               s_arvalid, s_araddr, s_arlen, s_arid);
    end
    tick();
    s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive_beat(1, 32'hA0 + b, b == 3);
      #1; checks++;
      w_got = {m_rvalid, m_rdata, m_rlast};
      w_exp = exp_q.pop_front();
      if (w_got !== w_exp) begin
        errors++;
        $display("FAIL single_beat%0d got=%h exp=%h", b, w_got, w_exp);
      end
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1; checks++;
    if ({s_rready, m_rvalid, protocol_err} !== 4'b0) begin
      errors++;
      $display("FAIL single_idle got rr=%b rv=%b err=%b",
               s_rready, m_rvalid, protocol_err);
    end
  endtask

  task automatic test_alternate();
    logic [N-1:0] oh;
    do_reset();
    set_req(0, 26'h100, 4'd2, 4'd1);
    set_req(1, 26'h200, 4'd2, 4'd2);
    m_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      oh = '0;
      oh[k % 2] = 1'b1;
      #1; checks++;
      if (m_arready !== oh) begin
        errors++;
        $display("FAIL alt_grant%0d got=%b exp=%b", k, m_arready, oh);
      end
      tick();
      s_arready = 1'b1;
      #1; checks++;
      if (s_araddr !== ((k % 2 == 1) ? 26'h200 : 26'h100)) begin
        errors++;
        $display("FAIL alt_addr%0d got=%h", k, s_araddr);
      end
      tick();
      s_arready = 1'b0;
      for (int b = 0; b < 2; b++) begin
        drive_beat(k % 2, 32'(k * 16 + b), b == 1);
        #1; checks++;
        w_got = {m_rvalid, m_rdata, m_rlast};
        w_exp = exp_q.pop_front();
        if (w_got !== w_exp) begin
          errors++;
          $display("FAIL alt_beat%0d_%0d got=%h exp=%h", k, b, w_got, w_exp);
        end
        tick();
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
    end
    m_arvalid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, 26'h3FFFFFC, 4'd1, 4'd5);
    m_arvalid = 2'b01;
    tick();
    m_arvalid = '0;
    m_araddr  = '1;
    m_arlen   = '1;
    m_arid    = '1;
    for (int c = 0; c < 5; c++) begin
      #1; checks++;
      if ({s_arvalid, s_araddr, s_arlen, s_arid}
          !== {1'b1, 26'h3FFFFFC, 4'd1, 4'd5}) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b a=%h l=%h id=%h",
                 c, s_arvalid, s_araddr, s_arlen, s_arid);
      end
      tick();
    end
    s_arready = 1'b1;
    #1; checks++;
    if (s_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL stall_hs got=%b exp=1", s_arvalid);
    end
    tick();
    s_arready = 1'b0;
    #1; checks++;
    if ({s_arvalid, s_rready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_data got=%b exp=01", {s_arvalid, s_rready});
    end
    drive_beat(0, 32'h55, 1'b1);
    #1; checks++;
    w_got = {m_rvalid, m_rdata, m_rlast};
    w_exp = exp_q.pop_front();
    if (w_got !== w_exp) begin
      errors++;
      $display("FAIL stall_beat got=%h exp=%h", w_got, w_exp);
    end
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic test_mismatch();
    do_reset();
    set_req(0, 26'h40, 4'd4, 4'd3);
    m_arvalid = 2'b01;
    tick();
    m_arvalid = '0;
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(0, 32'hB0 + b, b == 1);
      #1; checks++;
      w_got = {m_rvalid, m_rdata, m_rlast};
      w_exp = exp_q.pop_front();
      if (w_got !== w_exp) begin
        errors++;
        $display("FAIL early_beat%0d got=%h exp=%h", b, w_got, w_exp);
      end
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1; checks++;
    if ({s_rready, protocol_err} !== 2'b01) begin
      errors++;
      $display("FAIL early_end got=%b exp=01", {s_rready, protocol_err});
    end
    set_req(1, 26'h80, 4'd1, 4'd4);
    m_arvalid = 2'b10;
    tick();
    m_arvalid = '0;
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    drive_beat(1, 32'hC0, 1'b1);
    #1; checks++;
    w_got = {m_rvalid, m_rdata, m_rlast};
    w_exp = exp_q.pop_front();
    if (w_got !== w_exp) begin
      errors++;
      $display("FAIL clean_beat got=%h exp=%h", w_got, w_exp);
    end
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1; checks++;
    if (protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b exp=1", protocol_err);
    end
  endtask

  task automatic test_len0();
    do_reset();
    set_req(0, 26'h60, 4'd0, 4'd1);
    m_arvalid = 2'b01;
    tick();
    m_arvalid = '0;
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    drive_beat(0, 32'hD0, 1'b1);
    #1; checks++;
    w_got = {m_rvalid, m_rdata, m_rlast};
    w_exp = exp_q.pop_front();
    if (w_got !== w_exp) begin
      errors++;
      $display("FAIL len0_beat got=%h exp=%h", w_got, w_exp);
    end
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1; checks++;
    if ({s_rready, protocol_err} !== 2'b00) begin
      errors++;
      $display("FAIL len0_end got=%b exp=00", {s_rready, protocol_err});
    end
    set_req(1, 26'h70, 4'd1, 4'd2);
    m_arvalid = 2'b10;
    tick();
    m_arvalid = '0;
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    drive_beat(1, 32'hD1, 1'b0);
    #1; checks++;
    w_got = {m_rvalid, m_rdata, m_rlast};
    w_exp = exp_q.pop_front();
    if (w_got !== w_exp) begin
      errors++;
      $display("FAIL nolast_beat got=%h exp=%h", w_got, w_exp);
    end
    tick();
    s_rvalid = 1'b0;
    #1; checks++;
    if ({s_rready, protocol_err} !== 2'b01) begin
      errors++;
      $display("FAIL nolast_end got=%b exp=01", {s_rready, protocol_err});
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_req(1, 26'h90, 4'd4, 4'd6);
    m_arvalid = 2'b10;
    tick();
    m_arvalid = '0;
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    drive_beat(1, 32'hE0, 1'b0);
    #1; checks++;
    w_got = {m_rvalid, m_rdata, m_rlast};
    w_exp = exp_q.pop_front();
    if (w_got !== w_exp) begin
      errors++;
      $display("FAIL rst_beat got=%h exp=%h", w_got, w_exp);
    end
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'hE1;
    #2;
    rst_n = 1'b0;
    #1; checks++;
    if ({m_rvalid, m_rdata, m_rlast, s_rready, s_arvalid, s_araddr,
         m_arready, protocol_err} !== '0) begin
      errors++;
      $display("FAIL async_reset got rv=%b d=%h rr=%b a=%h err=%b",
               m_rvalid, m_rdata, s_rready, s_araddr, protocol_err);
    end
    tick();
    s_rvalid = 1'b0;
    rst_n    = 1'b1;
    set_req(0, 26'h10, 4'd1, 4'd0);
    m_arvalid = 2'b11;
    #1; checks++;
    if (m_arready !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_grant got=%b exp=01", m_arready);
    end
    m_arvalid = '0;
  endtask

`ifdef MEM_READ_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    set_req(1, 26'h20, 4'd2, 4'd1);
    set_req(0, 26'h30, 4'd1, 4'd2);
    m_arvalid = 2'b10;
    tick();
    m_arvalid = 2'b11;
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(1, 32'hF0 + b, b == 1);
      #1; checks++;
      w_got = {m_rvalid, m_rdata, m_rlast};
      w_exp = exp_q.pop_front();
      if (w_got !== w_exp) begin
        errors++;
        $display("FAIL perf_beat%0d got=%h exp=%h", b, w_got, w_exp);
      end
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1; checks++;
    if (m_arready !== 2'b01) begin
      errors++;
      $display("FAIL perf_grant got=%b exp=01", m_arready);
    end
    tick();
    m_arvalid = '0;
    #1; checks++;
    if ({perf_wait[15:0], perf_grants[31:16], perf_grants[15:0]}
        !== {16'd3, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL perf_counts got w0=%0d g1=%0d g0=%0d exp 3 1 1",
               perf_wait[15:0], perf_grants[31:16], perf_grants[15:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_mismatch();
    test_len0();
    test_mid_reset();
`ifdef MEM_READ_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
